simplebus_mem_slave: RTL and testbench

SIMPLEBUS_MEM_SLAVE -- requirements
Module: simplebus_mem_slave

---
 rtl/simplebus_mem_slave.sv | 155 +++++++++++++++
 tb/tb_simplebus_mem_slave.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/simplebus_mem_slave.sv
// Single-outstanding SimpleBus memory slave: byte-masked writes, single and
// 8-beat wrapping burst reads, write bursts, fixed request-to-response latency.
module simplebus_mem_slave #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_ready,
  input  logic        req_valid,
  input  logic [31:0] req_bits_addr,
  input  logic [2:0]  req_bits_size,
  input  logic [3:0]  req_bits_cmd,
  input  logic [7:0]  req_bits_wmask,
  input  logic [63:0] req_bits_wdata,
  input  logic [15:0] req_bits_user,
  input  logic        resp_ready,
  output logic        resp_valid,
  output logic [3:0]  resp_bits_cmd,
  output logic [63:0] resp_bits_rdata,
  output logic [15:0] resp_bits_user
);

  localparam logic [3:0] CMD_READ      = 4'b0000;
  localparam logic [3:0] CMD_WRITE     = 4'b0001;
  localparam logic [3:0] CMD_RBURST    = 4'b0010;
  localparam logic [3:0] CMD_WBURST    = 4'b0011;
  localparam logic [3:0] CMD_WRESP     = 4'b0101;
  localparam logic [3:0] CMD_READ_LAST = 4'b0110;
  localparam logic [3:0] CMD_WLAST     = 4'b0111;

  typedef enum logic [1:0] {IDLE, WBURST, WAIT, RESP} state_e;
  typedef enum logic [1:0] {RT_READ, RT_BURST, RT_WRESP, RT_ERR} resp_e;

  state_e                state_q, state_d;
  resp_e                 rtype_q, req_rtype;
  logic [3:0]            lat_cnt_q;
  logic [2:0]            beat_q;
  logic [DEPTH_LOG2-1:0] idx_q, req_idx, rd_idx;
  logic [15:0]           user_q;
  logic [63:0]           rdata_q;
  logic [63:0]           mem [2**DEPTH_LOG2];

  logic       accept, do_write, do_resp, do_wburst;
  logic       lat_done, last_beat, rd_en;
  logic [2:0] rd_off;
  logic       unused_bits;

  // Size and the byte offset / upper address bits carry no meaning here.
  assign unused_bits = ^{req_bits_size, req_bits_addr[31:DEPTH_LOG2+3], req_bits_addr[2:0]};

  assign accept    = req_valid & req_ready;
  assign req_idx   = req_bits_addr[DEPTH_LOG2+2:3];
  assign lat_done  = (lat_cnt_q == 4'(LATENCY - 1));
  assign last_beat = (rtype_q != RT_BURST) || (beat_q == 3'd7);

  // Request decode: what an accepted command does in the current state.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    do_write  = 1'b0;
    do_resp   = 1'b0;
    do_wburst = 1'b0;
    req_rtype = RT_ERR;
    if (state_q == IDLE) begin
      case (req_bits_cmd)
        CMD_READ:             begin do_resp = 1'b1; req_rtype = RT_READ; end
        CMD_WRITE, CMD_WLAST: begin do_write = 1'b1; do_resp = 1'b1; req_rtype = RT_WRESP; end
        CMD_RBURST:           begin do_resp = 1'b1; req_rtype = RT_BURST; end
        CMD_WBURST:           begin do_write = 1'b1; do_wburst = 1'b1; end
        default:              do_resp = 1'b1;
      endcase
    end else if (state_q == WBURST) begin
      case (req_bits_cmd)
        CMD_WBURST: do_write = 1'b1;
        CMD_WLAST:  begin do_write = 1'b1; do_resp = 1'b1; req_rtype = RT_WRESP; end
        default:    do_resp = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = do_resp ? WAIT : (do_wburst ? WBURST : IDLE);
      WBURST:  if (accept && do_resp) state_d = WAIT;
      WAIT:    if (lat_done) state_d = RESP;
      RESP:    if (resp_ready && last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state is always assigned with <= so every register samples pre-edge values.
      rtype_q   <= RT_READ;
      idx_q     <= '0;
      user_q    <= '0;
      lat_cnt_q <= '0;
      beat_q    <= '0;
    end else begin
      if (accept && do_resp) begin
        rtype_q   <= req_rtype;
        idx_q     <= req_idx;
        user_q    <= req_bits_user;
        lat_cnt_q <= '0;
        beat_q    <= '0;
      end
      if (state_q == WAIT && !lat_done) lat_cnt_q <= lat_cnt_q + 4'd1;
      if (state_q == RESP && resp_ready) beat_q <= last_beat ? 3'd0 : beat_q + 3'd1;
    end
  end

  // Burst beats wrap inside the 64-byte line; the word for the next beat is
  // fetched on the edge that enters RESP or retires the current beat.
  assign rd_off = idx_q[2:0] + ((state_q == RESP) ? beat_q + 3'd1 : 3'd0);
  assign rd_idx = {idx_q[DEPTH_LOG2-1:3], rd_off};
  assign rd_en  = (state_q == WAIT && lat_done) ||
                  (state_q == RESP && resp_ready && !last_beat);

  // NOTE: the memory and its read register have no reset; contents survive rst and outputs are gated instead.
  always_ff @(posedge clk) begin
    if (accept && do_write) begin
      for (int b = 0; b < 8; b++) begin
        if (req_bits_wmask[b]) mem[req_idx][8*b +: 8] <= req_bits_wdata[8*b +: 8];
      end
    end
    if (rd_en) rdata_q <= mem[rd_idx];
  end

  always_comb begin
    req_ready       = rst && (state_q == IDLE || state_q == WBURST);
    resp_valid      = (state_q == RESP);
    resp_bits_cmd   = 4'd0;
    resp_bits_rdata = 64'd0;
    resp_bits_user  = 16'd0;
    if (state_q == RESP) begin
      resp_bits_user = user_q;
      case (rtype_q)
        RT_READ:  begin resp_bits_cmd = CMD_READ_LAST; resp_bits_rdata = rdata_q; end
        RT_BURST: begin
          resp_bits_cmd   = (beat_q == 3'd7) ? CMD_READ_LAST : CMD_READ;
          resp_bits_rdata = rdata_q;
        end
        RT_WRESP: resp_bits_cmd = CMD_WRESP;
        default:  resp_bits_cmd = CMD_READ_LAST;
      endcase
    end
  end

endmodule

// File: tb/tb_simplebus_mem_slave.sv
// Randomized bench for simplebus_mem_slave against a word-array memory model
// with per-byte written flags and an expected-beat queue.
module tb_simplebus_mem_slave;

  localparam int DL    = 10;
  localparam int LAT   = 2;
  localparam int WORDS = 1 << DL;

  logic        clk, rst;
  logic        req_ready, req_valid;
  logic [31:0] req_bits_addr;
  logic [2:0]  req_bits_size;
  logic [3:0]  req_bits_cmd;
  logic [7:0]  req_bits_wmask;
  logic [63:0] req_bits_wdata;
  logic [15:0] req_bits_user;
  logic        resp_ready, resp_valid;
  logic [3:0]  resp_bits_cmd;
  logic [63:0] resp_bits_rdata;
  logic [15:0] resp_bits_user;

  simplebus_mem_slave #(.DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_ready(req_ready), .req_valid(req_valid),
    .req_bits_addr(req_bits_addr), .req_bits_size(req_bits_size),
    .req_bits_cmd(req_bits_cmd), .req_bits_wmask(req_bits_wmask),
    .req_bits_wdata(req_bits_wdata), .req_bits_user(req_bits_user),
    .resp_ready(resp_ready), .resp_valid(resp_valid),
    .resp_bits_cmd(resp_bits_cmd), .resp_bits_rdata(resp_bits_rdata),
    .resp_bits_user(resp_bits_user)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0]  cmd;
    logic [63:0] data;
    logic [63:0] dmask;
    logic [15:0] user;
  } beat_t;

  beat_t       exp_q[$];
  logic [63:0] model_mem [WORDS];
  logic [7:0]  model_bv  [WORDS];
  bit          in_wb;
  int          acc_cyc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] bytes_to_mask(input logic [7:0] bv);
    logic [63:0] m;
    for (int b = 0; b < 8; b++) m[8*b +: 8] = {8{bv[b]}};
    return m;
  endfunction

  task automatic model_write(input int idx, input logic [7:0] mask, input logic [63:0] data);
    for (int b = 0; b < 8; b++) begin
      if (mask[b]) begin
        model_mem[idx][8*b +: 8] = data[8*b +: 8];
        model_bv[idx][b] = 1'b1;
      end
    end
  endtask

  task automatic push_read(input int idx, input logic [3:0] cmd, input logic [15:0] user);
    beat_t b;
    b.cmd = cmd; b.data = model_mem[idx]; b.dmask = bytes_to_mask(model_bv[idx]); b.user = user;
    exp_q.push_back(b);
  endtask

  task automatic push_fixed(input logic [3:0] cmd, input logic [15:0] user);
    beat_t b;
    b.cmd = cmd; b.data = 64'd0; b.dmask = '1; b.user = user;
    exp_q.push_back(b);
  endtask

  task automatic send_req(input logic [3:0] cmd, input logic [31:0] addr, input logic [7:0] mask,
                          input logic [63:0] data, input logic [15:0] user);
    int w = 0;
    @(negedge clk);
    req_bits_cmd = cmd; req_bits_addr = addr; req_bits_wmask = mask;
    req_bits_wdata = data; req_bits_user = user; req_bits_size = 3'($urandom);
    req_valid = 1'b1;
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) check("req_ready_wait", {63'd0, req_ready}, 64'd1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic get_beats(input bit toggle);
    int n = exp_q.size();
    int got = 0;
    int budget = 0;
    int first = -1;
    bit stalled = 0;
    logic [63:0] h_rd;
    logic [19:0] h_tag;
    beat_t e;
    while (got < n && budget < 100) begin
      @(negedge clk);
      budget++;
      resp_ready = toggle ? ~resp_ready : 1'b1;
      if (resp_valid) begin
        if (first < 0) first = cyc;
        if (stalled) begin
          check("stable_rdata", resp_bits_rdata, h_rd);
          check("stable_cmd_user", {44'd0, resp_bits_cmd, resp_bits_user}, {44'd0, h_tag});
        end
        if (resp_ready) begin
          e = exp_q.pop_front();
          check("resp_cmd", {60'd0, resp_bits_cmd}, {60'd0, e.cmd});
          check("resp_rdata", resp_bits_rdata & e.dmask, e.data & e.dmask);
          check("resp_user", {48'd0, resp_bits_user}, {48'd0, e.user});
          got++;
          stalled = 0;
        end else begin
          stalled = 1;
          h_rd = resp_bits_rdata;
          h_tag = {resp_bits_cmd, resp_bits_user};
        end
      end
    end
    check("beat_count", 64'(got), 64'(n));
    if (first >= 0) check("latency", 64'(first - acc_cyc), 64'(LAT));
    @(negedge clk);
    check("resp_valid_after_last", {63'd0, resp_valid}, 64'd0);
    exp_q.delete();
  endtask

  task automatic do_txn(input logic [3:0] cmd, input logic [31:0] addr, input logic [7:0] mask,
                        input logic [63:0] data, input logic [15:0] user, input bit toggle);
    int idx = int'(addr[DL+2:3]);
    if (!in_wb) begin
      case (cmd)
        4'h0:       push_read(idx, 4'h6, user);
        4'h1, 4'h7: begin model_write(idx, mask, data); push_fixed(4'h5, user); end
        4'h2: for (int k = 0; k < 8; k++)
                push_read((idx & ~7) | ((idx + k) % 8), (k == 7) ? 4'h6 : 4'h0, user);
        4'h3:       begin model_write(idx, mask, data); in_wb = 1; end
        default:    push_fixed(4'h6, user);
      endcase
    end else begin
      case (cmd)
        4'h3:    model_write(idx, mask, data);
        4'h7:    begin model_write(idx, mask, data); in_wb = 0; push_fixed(4'h5, user); end
        default: begin in_wb = 0; push_fixed(4'h6, user); end
      endcase
    end
    send_req(cmd, addr, mask, data, user);
    if (exp_q.size() > 0) get_beats(toggle);
    else begin
      @(negedge clk);
      check("no_resp_wburst", {63'd0, resp_valid}, 64'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, vectors=%0d", vectors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          saw;
    int          r;
    logic [3:0]  c;
    logic [31:0] a;
    rst = 1'b0; req_valid = 1'b0; req_bits_addr = '0; req_bits_size = '0; req_bits_cmd = '0;
    req_bits_wmask = '0; req_bits_wdata = '0; req_bits_user = '0; resp_ready = 1'b0;
    in_wb = 0;
    for (int i = 0; i < WORDS; i++) model_bv[i] = 8'h00;

    repeat (3) @(negedge clk);
    check("reset_req_ready", {63'd0, req_ready}, 64'd0);
    check("reset_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("reset_resp_cmd", {60'd0, resp_bits_cmd}, 64'd0);
    check("reset_resp_rdata", resp_bits_rdata, 64'd0);
    check("reset_resp_user", {48'd0, resp_bits_user}, 64'd0);
    rst = 1'b1;
    #1;
    check("req_ready_after_release", {63'd0, req_ready}, 64'd1);

    // Single write then read-back, then a partial-mask overwrite.
    do_txn(4'h1, 32'h100, 8'hFF, 64'h1122334455667788, 16'h5, 0);
    do_txn(4'h0, 32'h100, 8'h00, 64'd0, 16'h6, 0);
    do_txn(4'h1, 32'h100, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, 16'h7, 0);
    do_txn(4'h0, 32'h100, 8'h00, 64'd0, 16'h8, 0);

    // Wrapping burst read over a preloaded line, free-running and stalled.
    for (int k = 0; k < 8; k++) do_txn(4'h1, 32'h200 + 32'(8 * k), 8'hFF, 64'(k), 16'(16 + k), 0);
    do_txn(4'h2, 32'h210, 8'h00, 64'd0, 16'h20, 0);
    do_txn(4'h2, 32'h200, 8'h00, 64'd0, 16'h21, 1);

    // Write burst closed by writeLast, read back as a burst.
    for (int k = 0; k < 7; k++) do_txn(4'h3, 32'h300 + 32'(8 * k), 8'hFF, {$urandom, $urandom}, 16'h30, 0);
    do_txn(4'h7, 32'h338, 8'hFF, {$urandom, $urandom}, 16'h31, 0);
    do_txn(4'h2, 32'h300, 8'h00, 64'd0, 16'h32, 0);

    // Reset while a read is waiting: no response, memory preserved.
    do_txn(4'h1, 32'h400, 8'hFF, 64'hCAFEF00D12345678, 16'h40, 0);
    send_req(4'h0, 32'h400, 8'h00, 64'd0, 16'h41);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("midrst_req_ready", {63'd0, req_ready}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    in_wb = 0;
    #1;
    check("midrst_req_ready_release", {63'd0, req_ready}, 64'd1);
    saw = 0;
    repeat (8) begin
      @(negedge clk);
      saw |= resp_valid;
    end
    check("no_resp_after_rst", {63'd0, saw}, 64'd0);
    do_txn(4'h0, 32'h400, 8'h00, 64'd0, 16'h42, 0);

    // Random traffic, mostly confined to a small aliased window.
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1:    c = 4'h0;
        2, 3:    c = 4'h1;
        4:       c = 4'h2;
        5, 6:    c = 4'h3;
        7:       c = 4'h7;
        default: c = 4'($urandom);
      endcase
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a[12:0] = a[12:0] & 13'h01F8;
      do_txn(c, a, 8'($urandom), {$urandom, $urandom}, 16'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
